// File: rtl/pipelined_alu_hs.sv
// Handshaked multi-cycle ALU: logic, add/sub, compares, shifts and an
// iterative shift-add multiply, with NZCV flags held until writeback takes them.
module pipelined_alu_hs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_bit,
    output logic             negative_bit,
    output logic             carry_bit,
    output logic             overflow_bit
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t state;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic [SHAMT_W-1:0] sh;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     sll_w;
    logic [WIDTH:0]     srl_w;
    logic [WIDTH:0]     sra_w;

    logic [WIDTH-1:0]   ex_res;
    logic               ex_c;
    logic               ex_v;

    assign in_ready = (state == IDLE);

    // Extra bit on each shift catches the last bit shifted out as the carry.
    always_comb begin
        sh     = b_q[SHAMT_W-1:0];
        add_w  = {1'b0, a_q} + {1'b0, b_q};
        sub_w  = {1'b0, a_q} - {1'b0, b_q};
        sll_w  = {1'b0, a_q} << sh;
        srl_w  = {a_q, 1'b0} >> sh;
        sra_w  = $signed({a_q, 1'b0}) >>> sh;
        ex_res = '0;
        ex_c   = 1'b0;
        ex_v   = 1'b0;
        case (op_q)
            OP_AND:  ex_res = a_q & b_q;
            OP_OR:   ex_res = a_q | b_q;
            OP_XOR:  ex_res = a_q ^ b_q;
            OP_NOR:  ex_res = ~(a_q | b_q);
            OP_ADD: begin
                ex_res = add_w[WIDTH-1:0];
                ex_c   = add_w[WIDTH];
                ex_v   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                      && (add_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res = sub_w[WIDTH-1:0];
                ex_c   = sub_w[WIDTH];
                ex_v   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                      && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT:  ex_res = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: ex_res = WIDTH'(a_q < b_q);
            OP_SLL: begin
                ex_res = sll_w[WIDTH-1:0];
                ex_c   = sll_w[WIDTH];
            end
            OP_SRL: begin
                ex_res = srl_w[WIDTH:1];
                ex_c   = srl_w[0];
            end
            OP_SRA: begin
                ex_res = sra_w[WIDTH:1];
                ex_c   = sra_w[0];
            end
            default: begin
                ex_res = '0;
                ex_c   = 1'b0;
                ex_v   = 1'b0;
            end
        endcase
    end

    always_comb begin
        prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mcand_q      <= '0;
            prod_q       <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            out_valid    <= 1'b0;
            alu_result   <= '0;
            zero_bit     <= 1'b0;
            negative_bit <= 1'b0;
            carry_bit    <= 1'b0;
            overflow_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= alu_op;
                        a_q      <= alu_src1;
                        b_q      <= alu_src2;
                        mcand_q  <= {{WIDTH{1'b0}}, alu_src1};
                        mplier_q <= alu_src2;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        state    <= (alu_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    alu_result   <= ex_res;
                    zero_bit     <= (ex_res == '0);
                    negative_bit <= ex_res[WIDTH-1];
                    carry_bit    <= ex_c;
                    overflow_bit <= ex_v;
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                MUL: begin
                    prod_q   <= prod_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        alu_result   <= prod_nxt[WIDTH-1:0];
                        zero_bit     <= (prod_nxt[WIDTH-1:0] == '0);
                        negative_bit <= prod_nxt[WIDTH-1];
                        carry_bit    <= 1'b0;
                        overflow_bit <= |prod_nxt[2*WIDTH-1:WIDTH];
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_alu_hs.sv
// Bench for pipelined_alu_hs: 32- and 8-bit instances checked against an
// arithmetic reference model, with directed corner cases and random traffic.
module tb_pipelined_alu_hs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        iv;
    logic        ordy;
    logic        sel8;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic        ir32, ov32, z32, n32, c32, v32;
    logic [31:0] r32;
    logic        ir8, ov8, z8, n8, c8, v8;
    logic [7:0]  r8;

    logic        o_ir, o_ov, o_z, o_n, o_c, o_v;
    logic [31:0] o_r;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } res_t;

    pipelined_alu_hs #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (iv & ~sel8),
        .in_ready     (ir32),
        .alu_op       (op),
        .alu_src1     (a),
        .alu_src2     (b),
        .out_valid    (ov32),
        .out_ready    (ordy & ~sel8),
        .alu_result   (r32),
        .zero_bit     (z32),
        .negative_bit (n32),
        .carry_bit    (c32),
        .overflow_bit (v32)
    );

    pipelined_alu_hs #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (iv & sel8),
        .in_ready     (ir8),
        .alu_op       (op),
        .alu_src1     (a[7:0]),
        .alu_src2     (b[7:0]),
        .out_valid    (ov8),
        .out_ready    (ordy & sel8),
        .alu_result   (r8),
        .zero_bit     (z8),
        .negative_bit (n8),
        .carry_bit    (c8),
        .overflow_bit (v8)
    );

    always_comb begin
        o_ir = sel8 ? ir8 : ir32;
        o_ov = sel8 ? ov8 : ov32;
        o_r  = sel8 ? {24'd0, r8} : r32;
        o_z  = sel8 ? z8 : z32;
        o_n  = sel8 ? n8 : n32;
        o_c  = sel8 ? c8 : c32;
        o_v  = sel8 ? v8 : v32;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operation's meaning.
    function automatic res_t model(input logic [3:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input int w);
        longint unsigned m, ua, ub, full, rr;
        longint          sa, sb, s, smax, smin;
        int              sh;
        res_t            e;
        m    = (64'h1 << w) - 1;
        ua   = longint'(x) & m;
        ub   = longint'(y) & m;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (((ua >> (w - 1)) & 1) != 0) sa = sa - (longint'(1) << w);
        if (((ub >> (w - 1)) & 1) != 0) sb = sb - (longint'(1) << w);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sh   = int'(ub % longint'(w));
        rr   = 0;
        e    = '0;
        case (o)
            4'd0: rr = ua & ub;
            4'd1: rr = ua | ub;
            4'd2: rr = ua ^ ub;
            4'd3: rr = ~(ua | ub) & m;
            4'd4: begin
                full = ua + ub;
                rr   = full & m;
                e.c  = (full >> w) != 0;
                s    = sa + sb;
                e.v  = (s > smax) || (s < smin);
            end
            4'd5: begin
                rr  = (ua - ub) & m;
                e.c = ua < ub;
                s   = sa - sb;
                e.v = (s > smax) || (s < smin);
            end
            4'd6: rr = (sa < sb) ? 1 : 0;
            4'd7: rr = (ua < ub) ? 1 : 0;
            4'd8: begin
                rr  = (ua << sh) & m;
                e.c = (sh != 0) && (((ua >> (w - sh)) & 1) != 0);
            end
            4'd9: begin
                rr  = ua >> sh;
                e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
            end
            4'd10: begin
                s   = sa >>> sh;
                rr  = longint'(s) & m;
                e.c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
            end
            4'd11: begin
                full = ua * ub;
                rr   = full & m;
                e.v  = (full >> w) != 0;
            end
            default: rr = 0;
        endcase
        e.r = rr[31:0];
        e.z = (rr == 0);
        e.n = ((rr >> (w - 1)) & 1) != 0;
        return e;
    endfunction

    task automatic run(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int hold);
        int   w;
        int   lat;
        int   exp_lat;
        res_t e;
        w       = sel8 ? 8 : 32;
        e       = model(o, x, y, w);
        exp_lat = (o == 4'd11) ? w + 1 : 2;
        @(negedge clk);
        chk("in_ready_idle", 32'(o_ir), 32'd1);
        iv   = 1'b1;
        op   = o;
        a    = x;
        b    = y;
        ordy = 1'b0;
        @(negedge clk);
        iv  = 1'b0;
        lat = 1;
        while (!o_ov && lat < 100) begin
            chk("in_ready_busy", 32'(o_ir), 32'd0);
            iv = 1'($urandom);
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            @(negedge clk);
            lat++;
        end
        iv = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", o_r, e.r);
        chk("flags_zncv", 32'({o_z, o_n, o_c, o_v}),
            32'({e.z, e.n, e.c, e.v}));
        repeat (hold) begin
            iv = 1'($urandom);
            op = 4'($urandom);
            a  = $urandom;
            b  = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(o_ov), 32'd1);
            chk("hold_result", o_r, e.r);
            chk("hold_flags", 32'({o_z, o_n, o_c, o_v}),
                32'({e.z, e.n, e.c, e.v}));
            chk("hold_in_ready", 32'(o_ir), 32'd0);
        end
        iv   = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk("drain_valid", 32'(o_ov), 32'd0);
        chk("drain_in_ready", 32'(o_ir), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(o_ir), 32'd1);
        chk({tag, "_out_valid"}, 32'(o_ov), 32'd0);
        chk({tag, "_result"}, o_r, 32'd0);
        chk({tag, "_flags"}, 32'({o_z, o_n, o_c, o_v}), 32'd0);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0;
        iv      = 1'b0;
        ordy    = 1'b0;
        sel8    = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset32");
        sel8 = 1'b1;
        #1;
        chk_reset_outputs("reset8");
        sel8 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // 32-bit directed corners
        run(4'd4, 32'd5, 32'd7, 0);
        chk("add_5_7_const", o_r, 32'd12);
        run(4'd4, 32'h7FFF_FFFF, 32'h1, 0);
        run(4'd4, 32'hFFFF_FFFF, 32'h1, 0);
        run(4'd5, 32'd3, 32'd5, 0);
        run(4'd6, 32'hFFFF_FFFF, 32'h1, 0);
        run(4'd7, 32'hFFFF_FFFF, 32'h1, 0);
        run(4'd10, 32'h8000_0000, 32'h24, 0);
        run(4'd8, 32'h8000_0001, 32'h1, 0);
        run(4'd9, 32'h1, 32'h0, 0);
        run(4'd10, 32'h8000_0000, 32'h1F, 0);
        run(4'd11, 32'h0001_0000, 32'h0001_0000, 0);
        run(4'd11, 32'd6, 32'd7, 0);
        run(4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 5);
        run(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run(4'd3, 32'h0, 32'h0, 1);

        // reset in the middle of a multiply
        @(negedge clk);
        iv = 1'b1;
        op = 4'd11;
        a  = 32'hFFFF_FFFF;
        b  = 32'hFFFF_FFFF;
        @(negedge clk);
        iv = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_mul_reset");
        @(negedge clk);
        reset_n = 1'b1;
        ordy    = 1'b1;
        seen    = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | o_ov;
        end
        ordy = 1'b0;
        chk("no_valid_after_reset", 32'(seen), 32'd0);

        // 8-bit instance
        sel8 = 1'b1;
        run(4'd4, 32'h80, 32'h80, 0);
        run(4'd11, 32'd15, 32'd17, 0);
        run(4'd10, 32'h81, 32'h0F, 0);
        run(4'd5, 32'h80, 32'h01, 1);
        repeat (25) run(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));

        sel8 = 1'b0;
        repeat (40) run(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
